// File: rtl/apb_cipher_bridge.sv
// apb_cipher_bridge: APB slave with input/output block FIFOs feeding a block-cipher core; APB_CIPHER_IRQ_EN adds irq_o
module apb_cipher_bridge #(
  parameter int DATA_W    = 128,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_req_o,
  output logic              core_ack_o,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_valid_i,
  input  logic              core_busy_i
`ifdef APB_CIPHER_IRQ_EN
  ,
  output logic              irq_o
`endif
);
  localparam int NW  = DATA_W / 32;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;
  state_t            state;
  logic [DATA_W-1:0] in_mem  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [DATA_W-1:0] stage, nxt;
  logic [IAW-1:0]    in_wp, in_rp;
  logic [IAW:0]      in_count;
  logic [OAW-1:0]    out_wp, out_rp;
  logic [OAW:0]      out_count;
  logic [ADDR_W-7:0] hi;
  logic [31:0]       rdata, status;
  int                idx, wk;
  logic in_rng, acc, err, wr_ok, rd_ok, ctrl_sel, status_sel, irq_sel, din_sel, dout_sel;
  logic in_full, in_empty, out_full, out_empty, push_in, pop_in, push_out, pop_out, start;
  logic soft_clr, discard, irq_en, done, unused;
  assign unused = ^PADDR[1:0];
  // Address decode, error detection, byte-strobe merge and read mux
  always_comb begin
    acc        = PSEL & PENABLE;
    hi         = PADDR[ADDR_W-1:6];
    idx        = 32'(PADDR[5:2]);
    in_rng     = idx < NW;
    wk         = in_rng ? idx : 0;
    ctrl_sel   = hi == '0 & idx == 0;
    status_sel = hi == '0 & idx == 1;
    irq_sel    = hi == '0 & idx == 2;
    din_sel    = hi == (ADDR_W-6)'(1) & in_rng;
    dout_sel   = hi == (ADDR_W-6)'(2) & in_rng;
    in_full    = 32'(in_count) == IN_DEPTH;
    in_empty   = in_count == '0;
    out_full   = 32'(out_count) == OUT_DEPTH;
    out_empty  = out_count == '0;
    err = acc & (!(ctrl_sel | status_sel | irq_sel | din_sel | dout_sel)
               | PWRITE & (status_sel | dout_sel | PSTRB == 4'b0 | din_sel & wk == NW-1 & in_full)
               | !PWRITE & dout_sel & out_empty);
    wr_ok = acc & PWRITE & !err;
    rd_ok = acc & !PWRITE & !err;
    nxt = stage;
    for (int b = 0; b < 4; b++)
      if (PSTRB[b]) nxt[32*wk+8*b +: 8] = PWDATA[8*b +: 8];
    push_in  = wr_ok & din_sel & wk == NW-1;
    pop_out  = rd_ok & dout_sel & wk == NW-1;
    start    = state == IDLE & !in_empty & !core_busy_i & 32'(out_count) < OUT_DEPTH & !soft_clr;
    pop_in   = start;
    push_out = state == WAIT & core_valid_i & !discard & !soft_clr;
    status = {8'b0, 8'(out_count), 8'(in_count), 3'b0, out_empty, out_full, in_empty, in_full, core_busy_i};
    rdata = ctrl_sel   ? {23'b0, irq_en, 7'b0, soft_clr} :
            status_sel ? status :
            irq_sel    ? {31'b0, done} :
            din_sel    ? stage[32*wk +: 32] :
            dout_sel & !out_empty ? out_mem[out_rp][32*wk +: 32] : 32'b0;
    PREADY  = acc;
    PRDATA  = rd_ok ? rdata : 32'b0;
    PSLVERR = err;
  end
  // Staging register, soft-clear pulse and FIFO pointers/counts
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      stage     <= '0;
      soft_clr  <= 1'b0;
      in_wp     <= '0;
      in_rp     <= '0;
      in_count  <= '0;
      out_wp    <= '0;
      out_rp    <= '0;
      out_count <= '0;
    end else begin
      soft_clr  <= wr_ok & ctrl_sel & PSTRB[0] & PWDATA[0];
      stage     <= wr_ok & din_sel ? nxt : stage;
      in_wp     <= soft_clr ? '0 : in_wp + IAW'(push_in);
      in_rp     <= soft_clr ? '0 : in_rp + IAW'(pop_in);
      in_count  <= soft_clr ? '0 : in_count + (IAW+1)'(push_in) - (IAW+1)'(pop_in);
      out_wp    <= soft_clr ? '0 : out_wp + OAW'(push_out);
      out_rp    <= soft_clr ? '0 : out_rp + OAW'(pop_out);
      out_count <= soft_clr ? '0 : out_count + (OAW+1)'(push_out) - (OAW+1)'(pop_out);
    end
  // FIFO storage; contents are don't-care while empty so no reset
  always_ff @(posedge PCLK) begin
    if (push_in) in_mem[in_wp] <= nxt;
    if (push_out) out_mem[out_wp] <= core_data_i;
  end
  // Core handshake FSM; a soft clear during REQ/WAIT lets the block finish but drops its result
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state       <= IDLE;
      core_req_o  <= 1'b0;
      core_ack_o  <= 1'b0;
      core_data_o <= '0;
      discard     <= 1'b0;
    end else begin
      core_req_o <= 1'b0;
      core_ack_o <= 1'b0;
      discard    <= discard & state != ACK | soft_clr & (state == REQ | state == WAIT);
      case (state)
        IDLE: if (start) begin
          state       <= REQ;
          core_req_o  <= 1'b1;
          core_data_o <= in_mem[in_rp];
        end
        REQ:  state <= WAIT;
        WAIT: if (core_valid_i) begin
          state      <= ACK;
          core_ack_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef APB_CIPHER_IRQ_EN
  logic irq_en_d, done_d;
  always_comb begin
    irq_en_d = wr_ok & ctrl_sel & PSTRB[1] ? PWDATA[8] : irq_en;
    done_d   = push_out | done & !(soft_clr | wr_ok & irq_sel & PSTRB[0] & PWDATA[0]);
  end
  // Interrupt enable, sticky block_done (set beats W1C) and registered irq
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      irq_en <= irq_en_d;
      done   <= done_d;
      irq_o  <= irq_en_d & done_d;
    end
`else
  assign irq_en = 1'b0;
  assign done   = 1'b0;
`endif
endmodule
